// File: rtl/rr_grant_mux.sv
// Consumer stage for a 4-port round-robin arbiter: masks requests while the
// 2-entry output FIFO is full, accepts the granted beat, counts grants, flags illegal grants.
module rr_grant_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        in_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
  output logic [NUM_PORTS-1:0]        in_ready_o,
  output logic [NUM_PORTS-1:0]        arb_req_o,
  input  logic [NUM_PORTS-1:0]        arb_gnt_i,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [1:0]                  out_src_o,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS*CNT_W-1:0]  gnt_cnt_o,
  output logic                        err_o
);

  localparam int SRC_W = 2;
  localparam int ENT_W = SRC_W + DATA_W;
  localparam logic [NUM_PORTS-1:0] GNT_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  // Handshake: a beat transfers on a rising edge where its valid and ready are both
  // high; a producer holds valid and data stable until that edge.
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] cnt_d [NUM_PORTS];
  logic             err_q, err_d;

  logic              full, onehot, no_stray, legal, illegal, push, pop;
  logic [SRC_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;

  always_comb begin
    full       = (count_q == 2'd2);
    // Masking requests while full keeps the arbiter's rotation frozen under backpressure.
    arb_req_o  = in_valid_i & {NUM_PORTS{~full}};
    onehot     = (arb_gnt_i != '0) && ((arb_gnt_i & (arb_gnt_i - GNT_ONE)) == '0);
    no_stray   = ((arb_gnt_i & ~arb_req_o) == '0);
    legal      = onehot && no_stray;
    illegal    = (arb_gnt_i != '0) && !legal;
    in_ready_o = legal ? arb_gnt_i : '0;
    push       = |in_ready_o;
    pop        = out_valid_o & out_ready_i;

    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt_i[i]) begin
        gnt_idx  = SRC_W'(i);
        gnt_data = in_data_i[i*DATA_W +: DATA_W];
      end
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {gnt_idx, gnt_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    cnt_d = cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_ready_o[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    err_d = err_q | illegal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign out_valid_o              = (count_q != 2'd0);
  assign {out_src_o, out_data_o}  = mem_q[rd_ptr_q];
  assign err_o                    = err_q;

  always_comb begin
    gnt_cnt_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_rr_grant_mux.sv
// Bench for rr_grant_mux: a behavioural round-robin arbiter closes the grant loop and a
// scoreboard queue holds the expected {src, data} order of output beats.
module tb_rr_grant_mux;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NP-1:0]  in_valid = '0;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]  in_ready;
  logic [NP-1:0]  arb_req;
  logic [NP-1:0]  arb_gnt;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_src;
  logic           out_ready = 1'b0;
  logic [NP*CW-1:0] gnt_cnt;
  logic           err;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  logic [1:0]    rr_ptr;
  logic          force_en = 1'b0;
  logic [NP-1:0] force_gnt = '0;

  rr_grant_mux #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .arb_req_o(arb_req), .arb_gnt_i(arb_gnt),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src),
    .out_ready_i(out_ready), .gnt_cnt_o(gnt_cnt), .err_o(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // round-robin arbiter: highest priority at rr_ptr, pointer moves past the winner
  always_comb begin
    arb_gnt = '0;
    if (force_en) begin
      arb_gnt = force_gnt;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (arb_gnt == '0 && arb_req[(int'(rr_ptr) + k) % NP]) begin
          arb_gnt[(int'(rr_ptr) + k) % NP] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 2'd0;
    end else if (!force_en) begin
      for (int k = 0; k < NP; k++) begin
        if (arb_gnt[k]) rr_ptr <= 2'(k + 1);
      end
    end
  end

  // scoreboard: compare every accepted output beat with the head of exp_q
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got src=%0d data=%h exp none", out_src, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_src, out_data} !== mon_exp) begin
          errors++;
          $display("FAIL pop_beat got src=%0d data=%h exp src=%0d data=%h",
                   out_src, out_data, mon_exp[9:8], mon_exp[7:0]);
        end
      end
      pop_cnt++;
    end
  end

  // driver tasks
  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    force_en  = 1'b0;
    force_gnt = '0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_src, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h s=%0d e=%b exp all 0", out_valid, out_data, out_src, err);
    end
    checks++;
    if (gnt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 0", gnt_cnt);
    end
    checks++;
    if (arb_req !== 4'b1010) begin
      errors++;
      $display("FAIL reset_req got %b exp 1010", arb_req);
    end
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0010", in_ready);
    end
    in_valid = '0;
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    set_data(8'h11, 8'h00, 8'h00, 8'h00);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    exp_q.push_back({2'd0, 8'h11});
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0001 || arb_req !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got rdy=%b req=%b exp 0001", in_ready, arb_req);
    end
    @(posedge clk);
    #1 in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h s=%0d exp 1 11 0", out_valid, out_data, out_src);
    end
    checks++;
    if (gnt_cnt !== 32'h0000_0001) begin
      errors++;
      $display("FAIL single_cnt got %h exp 00000001", gnt_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    int pops0;
    do_reset();
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 8'hA0 + 8'(i % 4)});
    pops0     = pop_cnt;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    repeat (8) @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (pop_cnt - pops0 != 8) begin
      errors++;
      $display("FAIL rr_throughput got %0d beats exp 8", pop_cnt - pops0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt_cnt !== 32'h0202_0202) begin
      errors++;
      $display("FAIL rr_cnt got %h exp 02020202", gnt_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    in_valid = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      repeat (c == 0 ? 2 : 1) @(posedge clk);
      #1;
      checks++;
      if (arb_req !== 4'b0000 || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_full_mask got req=%b rdy=%b exp 0000 0000", arb_req, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hA0) begin
        errors++;
        $display("FAIL bp_head_hold got v=%b s=%0d d=%h exp 1 0 a0", out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    exp_q.push_back({2'd2, 8'hA2});
    exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    @(posedge clk);
    #1;
    checks++;
    if (arb_req !== 4'b1111) begin
      errors++;
      $display("FAIL bp_resume_req got %b exp 1111", arb_req);
    end
    repeat (4) @(posedge clk);
    #1 in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gnt_cnt !== 32'h0101_0202) begin
      errors++;
      $display("FAIL bp_cnt got %h exp 01010202", gnt_cnt);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    set_data(8'h00, 8'h55, 8'h66, 8'h00);
    exp_q.push_back({2'd1, 8'h55});
    exp_q.push_back({2'd2, 8'h66});
    in_valid = 4'b0010;
    @(posedge clk);
    #1;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'h66) begin
      errors++;
      $display("FAIL pushpop_head got v=%b s=%0d d=%h exp 1 2 66", out_valid, out_src, out_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_count got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_illegal_grant();
    do_reset();
    set_data(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    force_en  = 1'b1;
    force_gnt = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_gnt got err=%b v=%b exp 0 0", err, out_valid);
    end
    force_gnt = 4'b0011;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL multihot_ready got %b exp 0000", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL multihot_err got err=%b v=%b exp 1 0", err, out_valid);
    end
    force_gnt = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", err);
    end
    do_reset();
    set_data(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    in_valid  = 4'b1011;
    out_ready = 1'b1;
    force_en  = 1'b1;
    force_gnt = 4'b0100;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000 || arb_req !== 4'b1011) begin
      errors++;
      $display("FAIL stray_ready got rdy=%b req=%b exp 0000 1011", in_ready, arb_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_err got err=%b v=%b exp 1 0", err, out_valid);
    end
    force_gnt = 4'b0001;
    exp_q.push_back({2'd0, 8'hB0});
    @(posedge clk);
    #1;
    in_valid  = '0;
    force_gnt = '0;
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL legal_after_err got v=%b err=%b exp 1 1", out_valid, err);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({2'd0, 8'(i)});
      @(posedge clk);
      #1 in_data[7:0] = 8'(i + 1);
      if (i == 99) begin
        checks++;
        if (gnt_cnt !== 32'h0000_0064) begin
          errors++;
          $display("FAIL cnt_100 got %h exp 00000064", gnt_cnt);
        end
      end
      if (i == 254) begin
        checks++;
        if (gnt_cnt !== 32'h0000_00FF) begin
          errors++;
          $display("FAIL cnt_255 got %h exp 000000ff", gnt_cnt);
        end
      end
    end
    checks++;
    if (gnt_cnt !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL cnt_saturate got %h exp 000000ff", gnt_cnt);
    end
    #3 reset_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({out_valid, out_data, out_src, err} !== 12'h000 || gnt_cnt !== '0) begin
      errors++;
      $display("FAIL midreset got v=%b d=%h s=%0d e=%b cnt=%h exp all 0",
               out_valid, out_data, out_src, err, gnt_cnt);
    end
    checks++;
    if (arb_req !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_req got %b exp 0001", arb_req);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop_same_cycle();
    test_illegal_grant();
    test_saturate_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
